// File: rtl/thread_csr_array_pkg.sv
// Shared types and constants for the per-thread CSR array.
package thread_csr_array_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CMD_W = 2;
  localparam int unsigned ERR_W = 3;

  localparam logic [PC_W-1:0] START_PC = 32'h0000_1000;

  typedef enum logic [1:0] {
    TS_FREE  = 2'd0,
    TS_RUN   = 2'd1,
    TS_SLEEP = 2'd2
  } trd_state_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_INIT = 2'd0,
    CMD_SLP  = 2'd1,
    CMD_WAKE = 2'd2,
    CMD_KILL = 2'd3
  } trd_cmd_t;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_ID     = 3'd1,
    ERR_INIT_BUSY  = 3'd2,
    ERR_NOT_PARENT = 3'd3,
    ERR_NOT_VALID  = 3'd4
  } trd_err_t;

endpackage

// File: rtl/thread_csr_array_if.sv
// Command / PC-write / fetch-select bundle between thread decode, CSR array and fetch.
interface thread_csr_array_if
  import thread_csr_array_pkg::*;
#(
  parameter int unsigned NUM_TRD = 8
);
  localparam int unsigned TW = $clog2(NUM_TRD);

  logic                    cmd_vld;
  logic [CMD_W-1:0]        cmd_op;
  logic [TW-1:0]           obj_trd;
  logic [TW-1:0]           act_trd;
  logic [PC_W-1:0]         init_pc;
  logic                    pc_wr;
  logic [TW-1:0]           pc_wr_trd;
  logic [PC_W-1:0]         nxt_pc;
  logic                    sched_adv;

  logic [NUM_TRD-1:0]      valid_vec;
  logic [NUM_TRD-1:0]      running_vec;
  logic [NUM_TRD*TW-1:0]   par_trd_flat;
  logic                    sel_vld;
  logic [TW-1:0]           sel_trd;
  logic [PC_W-1:0]         sel_pc;
  logic                    err;
  logic [ERR_W-1:0]        err_code;

  modport master (
    output cmd_vld, cmd_op, obj_trd, act_trd, init_pc,
    output pc_wr, pc_wr_trd, nxt_pc, sched_adv,
    input  valid_vec, running_vec, par_trd_flat,
    input  sel_vld, sel_trd, sel_pc, err, err_code
  );

  modport slave (
    input  cmd_vld, cmd_op, obj_trd, act_trd, init_pc,
    input  pc_wr, pc_wr_trd, nxt_pc, sched_adv,
    output valid_vec, running_vec, par_trd_flat,
    output sel_vld, sel_trd, sel_pc, err, err_code
  );

endinterface

// File: rtl/thread_csr_array_rr_arbiter.sv
// Combinational round-robin search: first set request after i_ptr, wrapping, ending at i_ptr.
module thread_csr_array_rr_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_grant,
  output logic         o_found
);

  int unsigned w_idx;

  // Circular scan from i_ptr+1 through i_ptr itself; lowest offset wins.
  always_comb begin
    o_grant = i_ptr;
    o_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_found && i_req[W'(w_idx)]) begin
        o_found = 1'b1;
        o_grant = W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/thread_csr_array.sv
// Per-thread state/parent/PC array with command checking and round-robin fetch selector.
module thread_csr_array
  import thread_csr_array_pkg::*;
#(
  parameter int unsigned NUM_TRD  = 8,
  parameter int unsigned BOOT_TRD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  thread_csr_array_if.slave bus
);

  localparam int unsigned TW = $clog2(NUM_TRD);

  trd_state_t      r_state [NUM_TRD];
  logic [TW-1:0]   r_par   [NUM_TRD];
  logic [PC_W-1:0] r_pc    [NUM_TRD];
  logic            r_sel_vld;
  logic [TW-1:0]   r_sel_trd;
  logic            r_err;
  trd_err_t        r_err_code;

  trd_state_t      w_state_nxt [NUM_TRD];
  logic [TW-1:0]   w_par_nxt   [NUM_TRD];
  logic [PC_W-1:0] w_pc_nxt    [NUM_TRD];
  trd_err_t        w_err_nxt;
  logic [NUM_TRD-1:0] w_run_nxt;
  logic            w_obj_ok;
  logic            w_pcw_ok;
  logic [TW-1:0]   w_obj;
  trd_state_t      w_obj_st;
  logic [TW-1:0]   w_obj_par;
  logic [TW-1:0]   w_grant;
  logic            w_found;
  logic            w_resel;

  // Out-of-range IDs are possible only when NUM_TRD is not a power of two.
  assign w_obj_ok  = ({1'b0, bus.obj_trd}   < (TW+1)'(NUM_TRD));
  assign w_pcw_ok  = ({1'b0, bus.pc_wr_trd} < (TW+1)'(NUM_TRD));
  assign w_obj     = w_obj_ok ? bus.obj_trd : '0;
  assign w_obj_st  = r_state[w_obj];
  assign w_obj_par = r_par[w_obj];

  // Thread state register plus parent/PC storage; boot thread comes up running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TRD; i++) begin
        r_state[TW'(i)] <= (i == BOOT_TRD) ? TS_RUN : TS_FREE;
        r_par[TW'(i)]   <= (i == BOOT_TRD) ? TW'(BOOT_TRD) : '0;
        r_pc[TW'(i)]    <= START_PC;
      end
    end else begin
      r_state <= w_state_nxt;
      r_par   <= w_par_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next-state: PC write first so a legal INIT on the same thread overrides it.
  always_comb begin
    w_state_nxt = r_state;
    w_par_nxt   = r_par;
    w_pc_nxt    = r_pc;
    w_err_nxt   = ERR_NONE;
    if (bus.pc_wr && w_pcw_ok) w_pc_nxt[bus.pc_wr_trd] = bus.nxt_pc;
    if (bus.cmd_vld) begin
      if (!w_obj_ok) begin
        w_err_nxt = ERR_BAD_ID;
      end else begin
        case (trd_cmd_t'(bus.cmd_op))
          CMD_INIT: begin
            if (w_obj_st == TS_FREE) begin
              w_state_nxt[w_obj] = TS_RUN;
              w_par_nxt[w_obj]   = bus.act_trd;
              w_pc_nxt[w_obj]    = bus.init_pc;
            end else begin
              w_err_nxt = ERR_INIT_BUSY;
            end
          end
          CMD_SLP: begin
            if (bus.act_trd != w_obj_par)  w_err_nxt = ERR_NOT_PARENT;
            else if (w_obj_st != TS_RUN)   w_err_nxt = ERR_NOT_VALID;
            else                           w_state_nxt[w_obj] = TS_SLEEP;
          end
          CMD_WAKE: begin
            if (w_obj_st == TS_FREE) w_err_nxt = ERR_NOT_VALID;
            else                     w_state_nxt[w_obj] = TS_RUN;
          end
          CMD_KILL: begin
            if (bus.act_trd != w_obj_par)  w_err_nxt = ERR_NOT_PARENT;
            else if (w_obj_st == TS_FREE)  w_err_nxt = ERR_NOT_VALID;
            else                           w_state_nxt[w_obj] = TS_FREE;
          end
          default: w_err_nxt = ERR_NONE;
        endcase
      end
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    bus.valid_vec    = '0;
    bus.running_vec  = '0;
    bus.par_trd_flat = '0;
    for (int unsigned i = 0; i < NUM_TRD; i++) begin
      bus.valid_vec[TW'(i)]        = (r_state[TW'(i)] != TS_FREE);
      bus.running_vec[TW'(i)]      = (r_state[TW'(i)] == TS_RUN);
      bus.par_trd_flat[i*TW +: TW] = r_par[TW'(i)];
    end
  end

  // Running mask as it will be after this edge, for the selector search.
  always_comb begin
    w_run_nxt = '0;
    for (int unsigned i = 0; i < NUM_TRD; i++) begin
      w_run_nxt[TW'(i)] = (w_state_nxt[TW'(i)] == TS_RUN);
    end
  end

  thread_csr_array_rr_arbiter #(.N(NUM_TRD), .W(TW)) u_rr (
    .i_req   (w_run_nxt),
    .i_ptr   (r_sel_trd),
    .o_grant (w_grant),
    .o_found (w_found)
  );

  // Idle selector re-searches every cycle so a newly running thread is picked up.
  assign w_resel = !r_sel_vld || bus.sched_adv || !w_run_nxt[r_sel_trd];

  // Fetch selection register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_vld <= 1'b1;
      r_sel_trd <= TW'(BOOT_TRD);
    end else if (w_resel) begin
      r_sel_vld <= w_found;
      if (w_found) r_sel_trd <= w_grant;
    end
  end

  // Error pulse and sticky cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_err <= (w_err_nxt != ERR_NONE);
      if (w_err_nxt != ERR_NONE) r_err_code <= w_err_nxt;
    end
  end

  assign bus.sel_vld  = r_sel_vld;
  assign bus.sel_trd  = r_sel_trd;
  assign bus.sel_pc   = r_pc[r_sel_trd];
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_thread_csr_array.sv
module tb_thread_csr_array;
  import thread_csr_array_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  thread_csr_array_if #(.NUM_TRD(8)) if8 ();
  thread_csr_array_if #(.NUM_TRD(6)) if6 ();

  thread_csr_array #(.NUM_TRD(8), .BOOT_TRD(0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  thread_csr_array #(.NUM_TRD(6), .BOOT_TRD(0)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index 0 models the 8-thread DUT, index 1 the 6-thread DUT.
  // Thread state: 0 free, 1 run, 2 sleep.
  int          m_st  [2][8];
  int          m_par [2][8];
  logic [31:0] m_pc  [2][8];
  int          m_sel [2];
  bit          m_selv[2];
  bit          m_err [2];
  int          m_errc[2];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset(input int d);
    for (int i = 0; i < 8; i++) begin
      m_st[d][i]  = 0;
      m_par[d][i] = 0;
      m_pc[d][i]  = START_PC;
    end
    m_st[d][0] = 1;
    m_sel[d]   = 0;
    m_selv[d]  = 1'b1;
    m_err[d]   = 1'b0;
    m_errc[d]  = 0;
  endfunction

  function automatic void model_step(input int d, input int n, input bit vld, input int op,
                                     input int obj, input int act, input logic [31:0] ipc,
                                     input bit pcw, input int pcwt, input logic [31:0] npc,
                                     input bit adv);
    int code;
    bit found;
    int pick;
    code = 0;
    if (pcw && pcwt < n) m_pc[d][pcwt] = npc;
    if (vld) begin
      if (obj >= n) code = 1;
      else if (op == 0) begin
        if (m_st[d][obj] == 0) begin
          m_st[d][obj] = 1; m_par[d][obj] = act; m_pc[d][obj] = ipc;
        end else code = 2;
      end else if (op == 1) begin
        if (act != m_par[d][obj]) code = 3;
        else if (m_st[d][obj] != 1) code = 4;
        else m_st[d][obj] = 2;
      end else if (op == 2) begin
        if (m_st[d][obj] == 0) code = 4;
        else m_st[d][obj] = 1;
      end else begin
        if (act != m_par[d][obj]) code = 3;
        else if (m_st[d][obj] == 0) code = 4;
        else m_st[d][obj] = 0;
      end
    end
    m_err[d] = (code != 0);
    if (code != 0) m_errc[d] = code;
    if (!m_selv[d] || adv || m_st[d][m_sel[d]] != 1) begin
      found = 1'b0;
      pick  = m_sel[d];
      for (int k = 1; k <= n; k++) begin
        if (!found && m_st[d][(m_sel[d] + k) % n] == 1) begin
          found = 1'b1;
          pick  = (m_sel[d] + k) % n;
        end
      end
      m_selv[d] = found;
      m_sel[d]  = pick;
    end
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      int n;
      logic [63:0] ev, er, ep, ov, orn, op;
      logic [63:0] osv, ost, opc, oer, oec;
      n  = (d == 0) ? 8 : 6;
      ev = '0; er = '0; ep = '0;
      for (int i = 0; i < n; i++) begin
        ev[i] = (m_st[d][i] != 0);
        er[i] = (m_st[d][i] == 1);
        for (int b = 0; b < 3; b++) ep[i*3 + b] = m_par[d][i][b];
      end
      if (d == 0) begin
        ov = 64'(if8.valid_vec); orn = 64'(if8.running_vec); op = 64'(if8.par_trd_flat);
        osv = 64'(if8.sel_vld); ost = 64'(if8.sel_trd); opc = 64'(if8.sel_pc);
        oer = 64'(if8.err); oec = 64'(if8.err_code);
      end else begin
        ov = 64'(if6.valid_vec); orn = 64'(if6.running_vec); op = 64'(if6.par_trd_flat);
        osv = 64'(if6.sel_vld); ost = 64'(if6.sel_trd); opc = 64'(if6.sel_pc);
        oer = 64'(if6.err); oec = 64'(if6.err_code);
      end
      chk_eq($sformatf("valid_vec/n%0d", n), ov, ev);
      chk_eq($sformatf("running_vec/n%0d", n), orn, er);
      chk_eq($sformatf("par_flat/n%0d", n), op, ep);
      chk_eq($sformatf("sel_vld/n%0d", n), osv, 64'(m_selv[d]));
      chk_eq($sformatf("sel_trd/n%0d", n), ost, 64'(m_sel[d]));
      chk_eq($sformatf("sel_pc/n%0d", n), opc, 64'(m_pc[d][m_sel[d]]));
      chk_eq($sformatf("err/n%0d", n), oer, 64'(m_err[d]));
      chk_eq($sformatf("err_code/n%0d", n), oec, 64'(m_errc[d]));
    end
  endtask

  task automatic drive(input bit vld, input int op, input int obj, input int act,
                       input logic [31:0] ipc, input bit pcw, input int pcwt,
                       input logic [31:0] npc, input bit adv);
    if8.cmd_vld = vld;   if6.cmd_vld = vld;
    if8.cmd_op = 2'(op); if6.cmd_op = 2'(op);
    if8.obj_trd = 3'(obj); if6.obj_trd = 3'(obj);
    if8.act_trd = 3'(act); if6.act_trd = 3'(act);
    if8.init_pc = ipc;   if6.init_pc = ipc;
    if8.pc_wr = pcw;     if6.pc_wr = pcw;
    if8.pc_wr_trd = 3'(pcwt); if6.pc_wr_trd = 3'(pcwt);
    if8.nxt_pc = npc;    if6.nxt_pc = npc;
    if8.sched_adv = adv; if6.sched_adv = adv;
  endtask

  // One clock: drive at negedge, advance the model, check at the next negedge.
  task automatic step(input bit vld, input int op, input int obj, input int act,
                      input logic [31:0] ipc, input bit pcw, input int pcwt,
                      input logic [31:0] npc, input bit adv);
    drive(vld, op, obj, act, ipc, pcw, pcwt, npc, adv);
    model_step(0, 8, vld, op, obj, act, ipc, pcw, pcwt, npc, adv);
    model_step(1, 6, vld, op, obj, act, ipc, pcw, pcwt, npc, adv);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int exp_sel[4];
    logic [31:0] exp_pc[4];
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    compare_all();
    chk_eq("rst_valid", 64'(if8.valid_vec), 64'h01);
    chk_eq("rst_running", 64'(if8.running_vec), 64'h01);
    chk_eq("rst_sel_trd", 64'(if8.sel_trd), 64'd0);
    chk_eq("rst_sel_vld", 64'(if8.sel_vld), 64'd1);
    chk_eq("rst_sel_pc", 64'(if8.sel_pc), 64'(START_PC));
    chk_eq("rst_err", 64'(if8.err), 64'd0);

    // INIT then duplicate INIT
    step(1, 0, 3, 0, 32'h100, 0, 0, 0, 0);
    chk_eq("init3_valid", 64'(if8.valid_vec), 64'h09);
    step(1, 0, 3, 0, 32'h111, 0, 0, 0, 0);
    chk_eq("init_busy_err", 64'(if8.err), 64'd1);
    chk_eq("init_busy_code", 64'(if8.err_code), 64'd2);
    chk_eq("init_busy_valid", 64'(if8.valid_vec), 64'h09);
    step(1, 0, 5, 0, 32'h500, 0, 0, 0, 0);

    // Round-robin advance over 0/3/5
    exp_sel = '{3, 5, 0, 3};
    exp_pc  = '{32'h100, 32'h500, START_PC, 32'h100};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk_eq($sformatf("rr_sel_%0d", i), 64'(if8.sel_trd), 64'(exp_sel[i]));
      chk_eq($sformatf("rr_pc_%0d", i), 64'(if8.sel_pc), 64'(exp_pc[i]));
    end

    // Sleep: wrong parent, then legal sleep of the selected thread
    step(1, 1, 3, 5, 0, 0, 0, 0, 0);
    chk_eq("slp_notpar_code", 64'(if8.err_code), 64'd3);
    chk_eq("slp_notpar_run3", 64'(if8.running_vec[3]), 64'd1);
    step(1, 1, 3, 0, 0, 0, 0, 0, 0);
    chk_eq("slp_running", 64'(if8.running_vec), 64'h21);
    chk_eq("slp_sel_moves", 64'(if8.sel_trd), 64'd5);

    // Kill down to nothing running, then INIT revives the selector
    step(1, 3, 5, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0, 0);
    chk_eq("kill_all_running", 64'(if8.running_vec), 64'h00);
    chk_eq("kill_all_selv", 64'(if8.sel_vld), 64'd0);
    step(1, 0, 2, 0, 32'h222, 0, 0, 0, 1);
    chk_eq("revive_selv", 64'(if8.sel_vld), 64'd1);
    chk_eq("revive_sel", 64'(if8.sel_trd), 64'd2);

    // INIT wins over same-cycle PC write
    step(1, 0, 4, 2, 32'h200, 1, 4, 32'h300, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk_eq("init_vs_pcwr_sel", 64'(if8.sel_trd), 64'd4);
    chk_eq("init_vs_pcwr_pc", 64'(if8.sel_pc), 64'h200);

    // WAKE on free thread, WAKE on running thread, out-of-range ID on the 6-thread DUT
    step(1, 2, 1, 0, 0, 0, 0, 0, 0);
    chk_eq("wake_free_code", 64'(if8.err_code), 64'd4);
    step(1, 2, 2, 7, 0, 0, 0, 0, 0);
    chk_eq("wake_run_err", 64'(if8.err), 64'd0);
    step(1, 0, 7, 0, 32'h700, 0, 0, 0, 0);
    chk_eq("bad_id_code6", 64'(if6.err_code), 64'd1);
    chk_eq("bad_id_err8", 64'(if8.err), 64'd0);

    // Randomized traffic with one asynchronous reset in the middle
    for (int it = 0; it < 2000; it++) begin
      int obj, act, op, pcwt;
      bit vld, pcw, adv;
      if (it == 1000) begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      vld  = ($urandom_range(0, 9) < 7);
      op   = $urandom_range(0, 3);
      obj  = $urandom_range(0, 7);
      act  = ($urandom_range(0, 1) == 0) ? m_par[0][obj] : $urandom_range(0, 7);
      pcw  = ($urandom_range(0, 9) < 3);
      pcwt = $urandom_range(0, 7);
      adv  = $urandom_range(0, 1);
      step(vld, op, obj, act, $urandom, pcw, pcwt, $urandom, adv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/thread_csr_array.md
Name: thread_csr_array

Overview:
- Parametrised successor to the per-thread control/status register: a single block holding status, parent and PC for NUM_TRD hardware threads.
- Adds a per-thread state machine, a command port with coded errors, a boot thread that is live out of reset, and a registered round-robin selector that picks the next running thread for fetch.
- Sits between the thread-control instruction decode (init/sleep/wake/kill) and the fetch stage.

Parameters:
- NUM_TRD, 8, number of hardware threads; must be >= 2.
- TW, $clog2(NUM_TRD), thread ID width; derived, not overridden.
- BOOT_TRD, 0, thread that is valid and running after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  thread command valid
- cmd_op  in  2  command: 0 INIT, 1 SLP, 2 WAKE, 3 KILL
- obj_trd  in  TW  target thread of the command
- act_trd  in  TW  issuing thread
- init_pc  in  32  start PC for INIT
- pc_wr  in  1  write PC
- pc_wr_trd  in  TW  thread whose PC is written
- nxt_pc  in  32  PC value to write
- sched_adv  in  1  fetch consumed the current selection; advance
- valid_vec  out  NUM_TRD  per-thread valid
- running_vec  out  NUM_TRD  per-thread running
- par_trd_flat  out  NUM_TRD*TW  parent IDs; thread i occupies bits [i*TW +: TW]
- sel_vld  out  1  sel_trd and sel_pc are meaningful
- sel_trd  out  TW  selected running thread
- sel_pc  out  32  current PC of sel_trd (combinational read of the PC array)
- err  out  1  one-cycle error pulse, registered
- err_code  out  3  error cause; holds its value until the next err

Behaviour:
- Per-thread state is FREE, RUN or SLEEP.
  - valid = state != FREE.
  - running = state == RUN.
- Reset (asynchronous):
  - All threads go to FREE, parent 0, PC = START_PC.
  - BOOT_TRD then goes to RUN with parent = BOOT_TRD.
  - sel_vld=1, sel_trd=BOOT_TRD; err=0; err_code=NONE.
- Commands take effect at the clock edge where cmd_vld=1. At most one command per cycle. Legality is checked in this order; the first failing check sets the code:
  - obj_trd >= NUM_TRD -> BAD_ID.
  - INIT:
    - target FREE -> RUN, parent <= act_trd, PC <= init_pc.
    - target not FREE -> INIT_BUSY, no state change.
  - SLP:
    - act_trd != parent -> NOT_PARENT.
    - target not RUN -> NOT_VALID.
    - otherwise RUN -> SLEEP.
  - WAKE:
    - any parent or thread may wake.
    - SLEEP -> RUN.
    - RUN -> no change, no error.
    - FREE -> NOT_VALID.
  - KILL:
    - act_trd != parent -> NOT_PARENT.
    - target FREE -> NOT_VALID.
    - otherwise -> FREE, parent is retained.
    - Children of the killed thread are unaffected.
  - A rejected command changes no state and no PC.
- Error codes, defined in the package: NONE=0, BAD_ID=1, INIT_BUSY=2, NOT_PARENT=3, NOT_VALID=4.
  - err is asserted in the cycle after the offending command.
- PC write:
  - pc_wr updates the PC of pc_wr_trd in any state.
  - pc_wr_trd >= NUM_TRD is ignored, with no error.
  - If a legal INIT targets the same thread in the same cycle, init_pc wins.
- Selector (registered; the new selection is visible 1 cycle after the triggering edge):
  - Re-evaluate when sched_adv=1, or when the current sel_trd will not be RUN next cycle (it is slept or killed).
  - Search circularly from sel_trd+1, wrapping at NUM_TRD-1 -> 0, ending with sel_trd itself.
  - The search uses next-state running values and picks the first RUN thread.
  - If no thread is RUN: sel_vld=0 and sel_trd holds. When a thread later becomes RUN, sel_vld=1 with that thread on the next cycle.
  - If sched_adv=1 while sel_vld=0, it is ignored.
- A reset asserted mid-operation overrides everything immediately; there is no partial command commit.

Decomposition:
- Shared package, alongside START_PC:
  - thread state enum trd_state_t (FREE/RUN/SLEEP).
  - thread command enum trd_cmd_t.
  - thread error enum trd_err_t.
- One natural sub-module, rr_arbiter, parametrised on N.
  - Inputs: req vector, current pointer.
  - Output: next grant index plus a found flag.
  - Purely combinational; the select register stays in thread_csr_array.

Test Plan:
- Reset with NUM_TRD=8 -> valid_vec=8'h01, running_vec=8'h01, sel_trd=0, sel_vld=1, sel_pc=START_PC, err=0.
- INIT obj=3 act=0 init_pc=32'h100, then INIT obj=3 again -> first: valid_vec=8'h09 and PC3=32'h100; second: err pulse with err_code=2, state unchanged.
- Threads 0/3/5 running, sched_adv=1 for 4 cycles -> sel_trd sequence 3,5,0,3, with sel_pc tracking each thread's PC.
- SLP obj=3 act=5 -> err_code=3, thread 3 still RUN. SLP obj=3 act=0 -> running_vec bit3=0, and if sel_trd was 3 the selection moves to 5 without sched_adv.
- KILL obj=0 act=0 while 0 is the only running thread -> running_vec=0, sel_vld=0. Next, INIT obj=2 -> sel_vld=1, sel_trd=2 one cycle later.
- INIT obj=4 init_pc=32'h200 with pc_wr to thread 4, nxt_pc=32'h300, same cycle -> PC4=32'h200. A WAKE to a FREE thread -> err_code=4. obj_trd out of range with NUM_TRD=6 -> err_code=1.
